// File: rtl/boreal_sram_dma_arbiter.sv
// Round-robin arbiter/sequencer for the Boreal SRAM tile DMA port; re-issues pre-empted accesses.
// Define BOREAL_DMA_ARB_TIMEOUT_EN to abandon an access after MAX_RETRY attempts with resp_err.
module boreal_sram_dma_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_RETRY = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*32-1:0]       req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          resp_valid,
    output logic [31:0]              resp_rdata,
    output logic                     resp_err,
    output logic                     busy,
    output logic                     dma_sel,
    output logic                     dma_wr,
    output logic [ADDR_W-1:0]        dma_addr,
    output logic [31:0]              dma_wdata,
    input  logic [31:0]              dma_rdata,
    input  logic                     dma_ack
);
    localparam int unsigned IDX_W = $clog2(NREQ);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    grant_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

    logic                grant_found;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    ptr_next;
    logic [ADDR_W-1:0]   grant_addr;
    logic [31:0]         grant_wdata;
    logic                give_up;

    // Legal ranges: NREQ 2..8, MAX_RETRY 1..15.
    if (NREQ < 2 || NREQ > 8 || MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_param_range
    end

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign ptr_next    = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    assign grant_addr  = req_addr[32'(grant_idx) * ADDR_W +: ADDR_W];
    assign grant_wdata = req_wdata[32'(grant_idx) * 32 +: 32];
    assign busy        = (state_q != StIdle);

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && !rst && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_q    <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            dma_sel    <= 1'b0;
            dma_wr     <= 1'b0;
            dma_addr   <= '0;
            dma_wdata  <= '0;
        end else begin
            resp_valid <= '0;
            resp_rdata <= '0;
            unique case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        state_q   <= StIssue;
                        grant_q   <= grant_idx;
                        ptr_q     <= ptr_next;
                        wr_q      <= req_wr[grant_idx];
                        addr_q    <= grant_addr;
                        wdata_q   <= grant_wdata;
                        dma_sel   <= 1'b1;
                        dma_wr    <= req_wr[grant_idx];
                        dma_addr  <= grant_addr;
                        dma_wdata <= grant_wdata;
                    end
                end
                StIssue: begin
                    state_q   <= StWait;
                    dma_sel   <= 1'b0;
                    dma_wr    <= 1'b0;
                    dma_addr  <= '0;
                    dma_wdata <= '0;
                end
                StWait: begin
                    if (dma_ack) begin
                        state_q             <= StIdle;
                        resp_valid[grant_q] <= 1'b1;
                        resp_rdata          <= wr_q ? 32'h0 : dma_rdata;
                    end else if (give_up) begin
                        state_q             <= StIdle;
                        resp_valid[grant_q] <= 1'b1;
                    end else begin
                        // No ack means the bus port pre-empted us: re-issue the latched command.
                        state_q   <= StIssue;
                        dma_sel   <= 1'b1;
                        dma_wr    <= wr_q;
                        dma_addr  <= addr_q;
                        dma_wdata <= wdata_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef BOREAL_DMA_ARB_TIMEOUT_EN
    localparam logic [3:0] RetryLast = 4'(MAX_RETRY - 1);

    logic [3:0] retry_q;

    assign give_up = (retry_q == RetryLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_q  <= '0;
            resp_err <= 1'b0;
        end else begin
            resp_err <= (state_q == StWait) && !dma_ack && give_up;
            if (state_q == StIdle && grant_found) begin
                retry_q <= '0;
            end else if (state_q == StWait && !dma_ack && retry_q != 4'hF) begin
                retry_q <= retry_q + 4'd1;
            end
        end
    end
`else
    assign give_up  = 1'b0;
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_boreal_sram_dma_arbiter.sv
// Bench for boreal_sram_dma_arbiter: tile model with pre-emption, requester driver,
// scoreboard of expected responses, table-driven single transactions plus corner sequences.
module tb_boreal_sram_dma_arbiter;
    localparam int NREQ      = 4;
    localparam int ADDR_W    = 10;
    localparam int MAX_RETRY = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_wr = '0;
    logic [NREQ*ADDR_W-1:0] req_addr = '0;
    logic [NREQ*32-1:0]     req_wdata = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        resp_valid;
    logic [31:0]            resp_rdata;
    logic                   resp_err;
    logic                   busy;
    logic                   dma_sel;
    logic                   dma_wr;
    logic [ADDR_W-1:0]      dma_addr;
    logic [31:0]            dma_wdata;
    logic [31:0]            dma_rdata;
    logic                   dma_ack;

    boreal_sram_dma_arbiter #(
        .NREQ      (NREQ),
        .ADDR_W    (ADDR_W),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .dma_sel    (dma_sel),
        .dma_wr     (dma_wr),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_rdata  (dma_rdata),
        .dma_ack    (dma_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Tile model: registered ack one cycle after dma_sel unless the bus port steals the slot.
    logic [31:0] tile_mem [0:1023];
    logic        ack_q = 1'b0;
    logic [31:0] rd_q = '0;
    logic        inject_ack = 1'b0;
    int          block_limit = 0;
    int          block_epoch = 0;
    int          seen_epoch = 0;
    int          blocked = 0;

    assign dma_ack   = ack_q | inject_ack;
    assign dma_rdata = rd_q;

    always @(posedge clk) begin
        ack_q <= 1'b0;
        if (seen_epoch != block_epoch) begin
            seen_epoch <= block_epoch;
            blocked    <= 0;
        end else if (dma_sel) begin
            if (blocked < block_limit) begin
                blocked <= blocked + 1;
            end else begin
                ack_q <= 1'b1;
                rd_q  <= tile_mem[dma_addr];
                if (dma_wr) tile_mem[dma_addr] <= dma_wdata;
            end
        end
    end

    // Requester driver: requester i stays valid until it has been granted target[i] times.
    int          target [NREQ];
    int          gnt_count [NREQ];
    logic        rq_wr [NREQ];
    logic [9:0]  rq_addr [NREQ];
    logic [31:0] rq_wdata [NREQ];

    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]                  = (gnt_count[i] < target[i]);
            req_wr[i]                     = rq_wr[i];
            req_addr[i*ADDR_W +: ADDR_W]  = rq_addr[i];
            req_wdata[i*32 +: 32]         = rq_wdata[i];
        end
    end

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        int          gcyc;
        int          lat;
        int          sels;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb [$];
    int          grant_log [$];
    exp_t        mon_e;
    exp_t        new_e;
    logic [31:0] pend_rdata = '0;
    int          pend_lat = 3;
    int          pend_sels = 1;
    logic        pend_err = 1'b0;
    int          sel_cnt = 0;
    int          last_sel = 0;

    // Monitor: pop on completion, track dma_sel pulses, push an expectation on each grant.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (resp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_valid", 32'(resp_valid), 32'(1 << mon_e.idx));
                    check("resp_rdata", resp_rdata, mon_e.rdata);
                    check("resp_err", 32'(resp_err), 32'(mon_e.err));
                    check("resp_latency", cyc - mon_e.gcyc, mon_e.lat);
                    check("sel_pulses", sel_cnt, mon_e.sels);
                    check("resp_busy", 32'(busy), 32'd0);
                end
            end
            if (dma_sel) begin
                sel_cnt++;
                if (sel_cnt > 1) check("sel_gap", cyc - last_sel, 2);
                last_sel = cyc;
                check("sel_busy", 32'(busy), 32'd1);
                if (sb.size() == 0) begin
                    check("sel_unexpected", 32'(dma_sel), 32'd0);
                end else begin
                    check("dma_addr", 32'(dma_addr), 32'(sb[0].addr));
                    check("dma_wr", 32'(dma_wr), 32'(sb[0].wr));
                    check("dma_wdata", dma_wdata, sb[0].wdata);
                end
            end
            if (req_ready != '0) begin
                check("ready_onehot", $countones(req_ready), 1);
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        check("ready_valid", 32'(req_valid[i]), 32'd1);
                        new_e.idx   = i;
                        new_e.rdata = pend_rdata;
                        new_e.err   = pend_err;
                        new_e.gcyc  = cyc;
                        new_e.lat   = pend_lat;
                        new_e.sels  = pend_sels;
                        new_e.wr    = rq_wr[i];
                        new_e.addr  = rq_addr[i];
                        new_e.wdata = rq_wdata[i];
                        sb.push_back(new_e);
                        grant_log.push_back(i);
                        gnt_count[i]++;
                        sel_cnt = 0;
                    end
                end
            end
        end
    end

    function automatic logic pending();
        logic p = 1'b0;
        for (int i = 0; i < NREQ; i++) if (gnt_count[i] < target[i]) p = 1'b1;
        return p;
    endfunction

    task automatic wait_done(input int budget);
        int t = 0;
        while ((sb.size() != 0 || pending() || busy) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done: still active after %0d cycles, required idle", t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_block(input int n);
        block_limit = n;
        block_epoch++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input int r, input logic w, input logic [9:0] a, input logic [31:0] d,
                           input int blk, input logic [31:0] er, input int lat, input int sels,
                           input logic ee);
        set_block(blk);
        pend_rdata = er;
        pend_lat   = lat;
        pend_sels  = sels;
        pend_err   = ee;
        rq_wr[r]   = w;
        rq_addr[r] = a;
        rq_wdata[r] = d;
        grant_log.delete();
        target[r]++;
        wait_done(300);
        check("grant_count", grant_log.size(), 1);
        if (grant_log.size() > 0) check("grant_idx", grant_log[0], r);
    endtask

    typedef struct {
        int          r;
        logic        w;
        logic [9:0]  a;
        logic [31:0] d;
        int          blk;
        logic [31:0] er;
        int          lat;
        int          sels;
    } vec_t;

    vec_t vecs [7];
    int   rr_exp [5];
    int   t;

    initial begin
        vecs[0] = '{0, 1'b1, 10'd5,    32'hDEADBEEF, 0, 32'h0,        3, 1};
        vecs[1] = '{1, 1'b0, 10'd5,    32'h0,        0, 32'hDEADBEEF, 3, 1};
        vecs[2] = '{2, 1'b1, 10'd1023, 32'hA5A50001, 0, 32'h0,        3, 1};
        vecs[3] = '{3, 1'b0, 10'd1023, 32'h0,        0, 32'hA5A50001, 3, 1};
        vecs[4] = '{1, 1'b1, 10'd0,    32'h12345678, 2, 32'h0,        7, 3};
        vecs[5] = '{0, 1'b0, 10'd0,    32'h0,        2, 32'h12345678, 7, 3};
        vecs[6] = '{2, 1'b0, 10'd5,    32'h0,        1, 32'hDEADBEEF, 5, 2};
        rr_exp  = '{0, 1, 2, 3, 0};

        // Reset with every requester asserting.
        for (int i = 0; i < NREQ; i++) begin
            gnt_count[i] = 0;
            target[i]    = (i == 0) ? 2 : 1;
            rq_wr[i]     = 1'b1;
            rq_addr[i]   = 10'(16 + i);
            rq_wdata[i]  = 32'h1000 + 32'(i);
        end
        repeat (3) @(negedge clk);
        check("rst_req_valid_in", 32'(req_valid), 32'hF);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_dma_sel", 32'(dma_sel), 32'h0);
        check("rst_dma_wr", 32'(dma_wr), 32'h0);
        check("rst_dma_addr", 32'(dma_addr), 32'h0);
        check("rst_dma_wdata", dma_wdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_done(300);
        check("rr_count", grant_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) check("rr_order", grant_log[i], rr_exp[i]);
        end

        // Table: single transactions, including pre-empted ones.
        for (int v = 0; v < 7; v++) begin
            run_one(vecs[v].r, vecs[v].w, vecs[v].a, vecs[v].d, vecs[v].blk, vecs[v].er,
                    vecs[v].lat, vecs[v].sels, 1'b0);
        end

        // Fairness from a known pointer: req0 and req2 held valid for 3 grants each.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pend_rdata = '0;
        pend_lat   = 3;
        pend_sels  = 1;
        pend_err   = 1'b0;
        rq_wr[0] = 1'b1; rq_addr[0] = 10'd100; rq_wdata[0] = 32'h0000AAAA;
        rq_wr[2] = 1'b1; rq_addr[2] = 10'd102; rq_wdata[2] = 32'h0000CCCC;
        grant_log.delete();
        target[0] += 3;
        target[2] += 3;
        wait_done(300);
        check("fair_count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) check("fair_order", grant_log[i], (i % 2 == 0) ? 0 : 2);
        end

        // Persistent pre-emption.
`ifdef BOREAL_DMA_ARB_TIMEOUT_EN
        run_one(3, 1'b1, 10'd9, 32'hCAFEF00D, 1000, 32'h0, 2 * MAX_RETRY + 1, MAX_RETRY, 1'b1);
`else
        run_one(3, 1'b0, 10'd5, 32'h0, 6, 32'hDEADBEEF, 15, 7, 1'b0);
`endif

        // Reset in WAIT, then a stray ack after release.
        set_block(0);
        pend_rdata = 32'hDEADBEEF;
        pend_lat   = 3;
        pend_sels  = 1;
        pend_err   = 1'b0;
        rq_wr[1]   = 1'b0;
        rq_addr[1] = 10'd5;
        target[1]++;
        t = 0;
        while (!dma_sel && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mid_sel: no dma_sel within %0d cycles, required one", t);
        end
        @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        target[1] = gnt_count[1];
        sb.delete();
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_resp", 32'(resp_valid), 32'h0);
            check("mid_rst_busy", 32'(busy), 32'h0);
            check("mid_rst_sel", 32'(dma_sel), 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        inject_ack = 1'b1;
        @(posedge clk);
        #1;
        inject_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("late_ack_resp", 32'(resp_valid), 32'h0);
            check("late_ack_busy", 32'(busy), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
